// File: rtl/demap_pkg.sv
// demap_pkg: constellation and arbiter-state types shared by the demapper arbiter.
package demap_pkg;
    typedef enum logic [3:0] {QPSK = 4'd0, PSK8 = 4'd1, QAM16 = 4'd2, QAM64 = 4'd3} constellation_e;
    localparam logic [3:0] CONST_MAX = QAM64;
    typedef enum logic [1:0] {IDLE, BUSY, DROP} arb_state_e;
    function automatic logic supported(input logic [3:0] c);
        return c <= CONST_MAX;
    endfunction
endpackage

// File: rtl/demap_arbiter_if.sv
// demap_arbiter_if: source, demapper and LLR-output streams around demap_arbiter.
interface demap_arbiter_if;
    logic [31:0] s0_data, s1_data, d_data, r_data, m_data;
    logic        s0_last, s1_last, s0_valid, s1_valid, s0_ready, s1_ready;
    logic [3:0]  s0_constellation, s1_constellation, d_constellation;
    logic [15:0] s0_scale, s1_scale, d_two_over_sigma_sq;
    logic        d_last, d_valid, d_ready, r_last, r_valid, r_ready;
    logic        m_last, m_valid, m_ready, m_chan;
    modport slave (
        input  s0_data, s1_data, s0_last, s1_last, s0_valid, s1_valid,
               s0_constellation, s1_constellation, s0_scale, s1_scale,
               d_ready, r_data, r_last, r_valid, m_ready,
        output s0_ready, s1_ready, d_data, d_last, d_valid, d_constellation,
               d_two_over_sigma_sq, r_ready, m_data, m_last, m_valid, m_chan
    );
    modport master (
        output s0_data, s1_data, s0_last, s1_last, s0_valid, s1_valid,
               s0_constellation, s1_constellation, s0_scale, s1_scale,
               d_ready, r_data, r_last, r_valid, m_ready,
        input  s0_ready, s1_ready, d_data, d_last, d_valid, d_constellation,
               d_two_over_sigma_sq, r_ready, m_data, m_last, m_valid, m_chan
    );
endinterface

// File: rtl/demap_tag_fifo.sv
// demap_tag_fifo: 1-bit grant-order tag FIFO; head is read from registered storage.
module demap_tag_fifo #(parameter int DEPTH = 4) (
    input  logic clk,
    input  logic rstf,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW:0] wp, rp;
    always_ff @(posedge clk or negedge rstf)
        if (!rstf) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
endmodule

// File: rtl/demap_arbiter.sv
// demap_arbiter: packet-granular round-robin sharing of one demapper between two sources.
// DEMAP_ARB_STATS_EN adds per-channel completed-packet and drop counters.
module demap_arbiter import demap_pkg::*; #(parameter int TAG_DEPTH = 4) (
    input  logic clk,
    input  logic rstf,
    demap_arbiter_if.slave bus,
    output logic err_orphan
`ifdef DEMAP_ARB_STATS_EN
    ,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic [15:0] drop_cnt
`endif
);
    arb_state_e state, state_nx;
    logic grant, prio, gnt_ch, take, push, pop, full, empty, head;
    logic src_valid, src_last;
    logic [3:0] g_cons;
    assign gnt_ch    = (bus.s0_valid && bus.s1_valid) ? prio : bus.s1_valid;
    assign g_cons    = gnt_ch ? bus.s1_constellation : bus.s0_constellation;
    assign take      = state == IDLE && (bus.s0_valid || bus.s1_valid) && !full;
    assign push      = take && supported(g_cons);
    assign src_valid = grant ? bus.s1_valid : bus.s0_valid;
    assign src_last  = grant ? bus.s1_last : bus.s0_last;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = supported(g_cons) ? BUSY : DROP;
            BUSY:    if (src_valid && bus.d_ready && src_last) state_nx = IDLE;
            DROP:    if (src_valid && src_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        bus.d_valid  = state == BUSY && src_valid;
        bus.d_last   = state == BUSY && src_last;
        bus.d_data   = state == BUSY ? (grant ? bus.s1_data : bus.s0_data) : '0;
        bus.s0_ready = !grant && (state == DROP || (state == BUSY && bus.d_ready));
        bus.s1_ready = grant && (state == DROP || (state == BUSY && bus.d_ready));
    end
    // constellation and scale move only on the IDLE grant so the final multiply sees them intact
    always_ff @(posedge clk or negedge rstf)
        if (!rstf) begin
            state                   <= IDLE;
            grant                   <= 1'b0;
            prio                    <= 1'b0;
            bus.d_constellation     <= '0;
            bus.d_two_over_sigma_sq <= '0;
            err_orphan              <= 1'b0;
        end else begin
            state      <= state_nx;
            err_orphan <= err_orphan || (bus.r_valid && empty);
            if (take) begin
                grant                   <= gnt_ch;
                prio                    <= !gnt_ch;
                bus.d_constellation     <= g_cons;
                bus.d_two_over_sigma_sq <= gnt_ch ? bus.s1_scale : bus.s0_scale;
            end
        end
    assign pop         = bus.r_valid && bus.m_ready && bus.r_last && !empty;
    assign bus.m_data  = bus.r_data;
    assign bus.m_last  = bus.r_last;
    assign bus.m_valid = bus.r_valid;
    assign bus.r_ready = bus.m_ready;
    assign bus.m_chan  = empty ? 1'b0 : head;
    demap_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk), .rstf(rstf), .push(push), .pop(pop), .din(gnt_ch),
        .head(head), .full(full), .empty(empty)
    );
`ifdef DEMAP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstf)
        if (!rstf) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop && !head) pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (pop && head) pkt_cnt1 <= pkt_cnt1 + 1'b1;
            if (take && !supported(g_cons)) drop_cnt <= drop_cnt + 1'b1;
        end
`endif
endmodule
